uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser_pkg.sv | 25 ++
 rtl/uart_frame_parser.sv | 146 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser.
// Holds FSM state encodings, frame constants and error codes.
package uart_frame_parser_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      GET_LEN     = 3'd1,
      GET_PAYLOAD = 3'd2,
      GET_CHK     = 3'd3,
      HOLD        = 3'd4
   } state_t;

   localparam logic [7:0] SOF     = 8'hA5;
   localparam int         MAX_LEN = 16;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TO   = 2'd3;

   function automatic logic len_ok(input logic [7:0] len);
      return (len != 8'd0) && (len <= 8'(MAX_LEN));
   endfunction

endpackage

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CHK frames from a UART byte stream and holds
// a verified payload until the consumer acknowledges it.
// Ports:
//   i_Clock, i_Reset (async, active-high)
//   i_RX_DV, i_RX_Byte : byte strobe and data from the UART receiver
//   i_Frame_Ack        : releases a held frame
//   i_Rd_Addr/o_Rd_Data: combinational payload buffer read port
//   o_Frame_Ready, o_Frame_Len : held-frame status
//   o_Busy             : frame reception in progress
//   o_Err, o_Err_Code  : one-cycle error pulse and sticky cause
module uart_frame_parser
   import uart_frame_parser_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 4160
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_Frame_Ack,
   input  logic [3:0] i_Rd_Addr,
   output logic [7:0] o_Rd_Data,
   output logic       o_Frame_Ready,
   output logic [4:0] o_Frame_Len,
   output logic       o_Busy,
   output logic       o_Err,
   output logic [1:0] o_Err_Code
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   state_t        state;
   logic [7:0]    buffer [MAX_LEN];
   logic [4:0]    len;
   logic [3:0]    idx;
   logic [7:0]    sum;
   logic [TW-1:0] to_cnt;
   logic [7:0]    chk_sum;
   logic          in_frame;
   logic          to_hit;
   logic          buf_we;

   assign in_frame = (state == GET_LEN) ||
                     (state == GET_PAYLOAD) ||
                     (state == GET_CHK);

   // A strobe on the terminal count still counts as a byte.
   assign to_hit  = in_frame && !i_RX_DV &&
                    (to_cnt == TW'(TIMEOUT_CLKS - 1));
   assign chk_sum = sum + i_RX_Byte;
   assign buf_we  = (state == GET_PAYLOAD) && i_RX_DV;

   assign o_Rd_Data = buffer[i_Rd_Addr];

   // Payload storage is intentionally not reset.
   always_ff @(posedge i_Clock) begin
      if (buf_we)
         buffer[idx] <= i_RX_Byte;
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state         <= IDLE;
         len           <= '0;
         idx           <= '0;
         sum           <= '0;
         to_cnt        <= '0;
         o_Frame_Ready <= 1'b0;
         o_Frame_Len   <= '0;
         o_Busy        <= 1'b0;
         o_Err         <= 1'b0;
         o_Err_Code    <= ERR_NONE;
      end else begin
         o_Err <= 1'b0;

         if (in_frame && !i_RX_DV)
            to_cnt <= to_cnt + TW'(1);
         else
            to_cnt <= '0;

         if (to_hit) begin
            state      <= IDLE;
            o_Busy     <= 1'b0;
            o_Err      <= 1'b1;
            o_Err_Code <= ERR_TO;
         end else begin
            unique case (state)
               IDLE: begin
                  if (i_RX_DV && i_RX_Byte == SOF) begin
                     state  <= GET_LEN;
                     o_Busy <= 1'b1;
                  end
               end
               GET_LEN: begin
                  if (i_RX_DV) begin
                     if (len_ok(i_RX_Byte)) begin
                        len   <= i_RX_Byte[4:0];
                        sum   <= i_RX_Byte;
                        idx   <= '0;
                        state <= GET_PAYLOAD;
                     end else begin
                        state      <= IDLE;
                        o_Busy     <= 1'b0;
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_LEN;
                     end
                  end
               end
               GET_PAYLOAD: begin
                  if (i_RX_DV) begin
                     sum <= chk_sum;
                     idx <= idx + 4'd1;
                     if ({1'b0, idx} == len - 5'd1)
                        state <= GET_CHK;
                  end
               end
               GET_CHK: begin
                  if (i_RX_DV) begin
                     o_Busy <= 1'b0;
                     if (chk_sum == 8'd0) begin
                        state         <= HOLD;
                        o_Frame_Ready <= 1'b1;
                        o_Frame_Len   <= len;
                     end else begin
                        state      <= IDLE;
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_CHK;
                     end
                  end
               end
               HOLD: begin
                  if (i_Frame_Ack) begin
                     state         <= IDLE;
                     o_Frame_Ready <= 1'b0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: frame-level reference model
// compared every cycle, plus directed literal expectations.
module tb_uart_frame_parser;

   localparam int T = 24;

   logic       i_Clock = 1'b0;
   logic       i_Reset;
   logic       i_RX_DV;
   logic [7:0] i_RX_Byte;
   logic       i_Frame_Ack;
   logic [3:0] i_Rd_Addr;
   logic [7:0] o_Rd_Data;
   logic       o_Frame_Ready;
   logic [4:0] o_Frame_Len;
   logic       o_Busy;
   logic       o_Err;
   logic [1:0] o_Err_Code;

   int n_chk   = 0;
   int n_fail  = 0;
   int err_cnt = 0;

   uart_frame_parser #(.TIMEOUT_CLKS(T)) dut (
      .i_Clock       (i_Clock),
      .i_Reset       (i_Reset),
      .i_RX_DV       (i_RX_DV),
      .i_RX_Byte     (i_RX_Byte),
      .i_Frame_Ack   (i_Frame_Ack),
      .i_Rd_Addr     (i_Rd_Addr),
      .o_Rd_Data     (o_Rd_Data),
      .o_Frame_Ready (o_Frame_Ready),
      .o_Frame_Len   (o_Frame_Len),
      .o_Busy        (o_Busy),
      .o_Err         (o_Err),
      .o_Err_Code    (o_Err_Code)
   );

   always #5 i_Clock = ~i_Clock;

   // Frame-level reference model
   logic [7:0] q[$];
   logic [7:0] m_buf [16];
   logic       m_hold, m_col, m_err;
   logic [1:0] m_code;
   int         m_len, m_gap;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic fail_frame(input logic [1:0] c);
      m_col  = 1'b0;
      m_err  = 1'b1;
      m_code = c;
   endtask

   task automatic model_step();
      logic [7:0] s;
      m_err = 1'b0;
      if (i_Reset) begin
         m_hold = 0; m_col = 0; q.delete();
         m_gap = 0; m_len = 0; m_code = 0;
         return;
      end
      if (m_hold) begin
         if (i_Frame_Ack) m_hold = 1'b0;
      end else if (!m_col) begin
         if (i_RX_DV && i_RX_Byte == 8'hA5) begin
            m_col = 1'b1; q.delete(); m_gap = 0;
         end
      end else if (i_RX_DV) begin
         m_gap = 0;
         q.push_back(i_RX_Byte);
         if (q.size() == 1 && (q[0] == 0 || q[0] > 16))
            fail_frame(2'd1);
         else if (q.size() == int'(q[0]) + 2) begin
            s = 8'd0;
            foreach (q[k]) s = s + q[k];
            if (s == 8'd0) begin
               m_hold = 1'b1; m_col = 1'b0; m_len = int'(q[0]);
               for (int k = 0; k < m_len; k++) m_buf[k] = q[k+1];
            end else
               fail_frame(2'd2);
         end
      end else begin
         m_gap++;
         if (m_gap == T) fail_frame(2'd3);
      end
   endtask

   always @(posedge i_Clock) begin
      model_step();
      #1;
      check("ready", o_Frame_Ready, m_hold);
      check("busy", o_Busy, m_col);
      check("err", o_Err, m_err);
      check("err_code", o_Err_Code, m_code);
      if (m_hold || i_Reset)
         check("frame_len", o_Frame_Len, m_len);
      if (m_hold && int'(i_Rd_Addr) < m_len)
         check("rd_data", o_Rd_Data, m_buf[i_Rd_Addr]);
      if (o_Err) err_cnt++;
   end

   // Stimulus helpers: called and returning on a falling edge
   task automatic send(input logic [7:0] b, input int idle);
      i_RX_DV = 1'b1;
      i_RX_Byte = b;
      @(negedge i_Clock);
      i_RX_DV = 1'b0;
      i_RX_Byte = 8'h00;
      repeat (idle) @(negedge i_Clock);
   endtask

   task automatic ack();
      i_Frame_Ack = 1'b1;
      @(negedge i_Clock);
      i_Frame_Ack = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] exp,
                     input string nm);
      i_Rd_Addr = a;
      #1;
      check(nm, o_Rd_Data, exp);
   endtask

   task automatic good_frame();
      send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1);
      send(8'h22, 1); send(8'h33, 1); send(8'h97, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int e0;
      logic [7:0] s;
      i_Reset = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
      i_Frame_Ack = 1'b0; i_Rd_Addr = 4'd0;
      repeat (3) @(negedge i_Clock);
      check("rst_ready", o_Frame_Ready, 0);
      check("rst_busy", o_Busy, 0);
      check("rst_code", o_Err_Code, 0);
      check("rst_len", o_Frame_Len, 0);
      i_Reset = 1'b0;
      repeat (2) @(negedge i_Clock);

      // Good frame
      e0 = err_cnt;
      good_frame();
      check("good_ready", o_Frame_Ready, 1);
      check("good_len", o_Frame_Len, 3);
      rd(4'd0, 8'h11, "good_rd0");
      rd(4'd1, 8'h22, "good_rd1");
      rd(4'd2, 8'h33, "good_rd2");
      check("good_noerr", err_cnt - e0, 0);
      @(negedge i_Clock);
      ack();
      repeat (2) @(negedge i_Clock);

      // Bad checksum
      e0 = err_cnt;
      send(8'hA5, 1); send(8'h02, 1); send(8'h10, 1);
      send(8'h20, 1); send(8'h00, 2);
      check("chk_errs", err_cnt - e0, 1);
      check("chk_code", o_Err_Code, 2);
      check("chk_ready", o_Frame_Ready, 0);
      check("chk_busy", o_Busy, 0);

      // Length errors
      e0 = err_cnt;
      send(8'hA5, 1); send(8'h00, 2);
      check("len0_errs", err_cnt - e0, 1);
      check("len0_code", o_Err_Code, 1);
      send(8'hA5, 1); send(8'h11, 2);
      check("len17_errs", err_cnt - e0, 2);
      check("len17_code", o_Err_Code, 1);

      // Maximum length frame
      send(8'hA5, 1); send(8'h10, 1);
      s = 8'h10;
      for (int k = 1; k <= 16; k++) begin
         send(8'(k), 0);
         s = s + 8'(k);
      end
      send(8'h00 - s, 0);
      check("max_ready", o_Frame_Ready, 1);
      check("max_len", o_Frame_Len, 16);
      rd(4'd15, 8'h10, "max_rd15");
      ack();
      repeat (2) @(negedge i_Clock);

      // Timeout
      e0 = err_cnt;
      send(8'hA5, 1); send(8'h04, 1); send(8'hAA, T + 2);
      check("to_errs", err_cnt - e0, 1);
      check("to_code", o_Err_Code, 3);
      check("to_busy", o_Busy, 0);

      // Gaps one short of the timeout are accepted
      e0 = err_cnt;
      send(8'hA5, T - 1); send(8'h01, T - 1);
      send(8'h55, T - 1); send(8'hAA, 0);
      check("edge_errs", err_cnt - e0, 0);
      check("edge_ready", o_Frame_Ready, 1);
      check("edge_len", o_Frame_Len, 1);
      rd(4'd0, 8'h55, "edge_rd0");
      ack();
      repeat (2) @(negedge i_Clock);

      // Frame while holding is dropped
      good_frame();
      send(8'hA5, 0); send(8'h02, 0); send(8'h01, 0);
      send(8'h02, 0); send(8'hFB, 1);
      check("hold_len", o_Frame_Len, 3);
      rd(4'd0, 8'h11, "hold_rd0");
      rd(4'd1, 8'h22, "hold_rd1");
      rd(4'd2, 8'h33, "hold_rd2");
      i_Frame_Ack = 1'b1;
      @(posedge i_Clock);
      #2;
      check("ack_drop", o_Frame_Ready, 0);
      @(negedge i_Clock);
      i_Frame_Ack = 1'b0;
      ack();
      send(8'hA5, 0); send(8'h02, 0); send(8'h01, 0);
      send(8'h02, 0); send(8'hFB, 0);
      check("new_ready", o_Frame_Ready, 1);
      check("new_len", o_Frame_Len, 2);
      rd(4'd1, 8'h02, "new_rd1");
      ack();
      repeat (2) @(negedge i_Clock);

      // Reset mid-payload, then garbage before a good frame
      e0 = err_cnt;
      send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1); send(8'h02, 1);
      i_Reset = 1'b1;
      #1;
      check("mid_rst_busy", o_Busy, 0);
      check("mid_rst_code", o_Err_Code, 0);
      repeat (2) @(negedge i_Clock);
      check("mid_rst_len", o_Frame_Len, 0);
      check("mid_rst_ready", o_Frame_Ready, 0);
      i_Reset = 1'b0;
      @(negedge i_Clock);
      send(8'h00, 1); send(8'hFF, 1);
      send(8'hA5, 1); send(8'h01, 1); send(8'h55, 1); send(8'hAA, 0);
      check("rst_errs", err_cnt - e0, 0);
      check("post_rst_ready", o_Frame_Ready, 1);
      check("post_rst_len", o_Frame_Len, 1);
      rd(4'd0, 8'h55, "post_rst_rd0");
      ack();
      repeat (3) @(negedge i_Clock);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
